lockin_frame_tx: RTL and testbench

//  Output-streaming stage of the lock-in chain; generalises the fixed 2-word I/Q streaming path to N_CH channels.

---
 rtl/lockin_frame_tx_pkg.sv | 19 +
 rtl/lockin_frame_tx_if.sv | 10 +
 rtl/lockin_frame_tx_sat_slice.sv | 37 +++
 rtl/lockin_frame_tx.sv | 153 +++++++++++++++
 tb/tb_lockin_frame_tx.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lockin_frame_tx_pkg.sv
// Shared types and helpers for the lock-in frame transmitter.
// FSM state encoding, default start-of-frame byte and payload length helper.
package lockin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  function automatic int nbytes(input int n_ch, input int out_w);
    return n_ch * 2 * out_w / 8;
  endfunction

endpackage

// File: rtl/lockin_frame_tx_if.sv
// Byte-stream link from the frame transmitter to the UART FIFO.
// master drives data/valid and sees ready; slave is the sink side.
interface lockin_frame_tx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/lockin_frame_tx_sat_slice.sv
// Combinational gain shift: arithmetic right shift of a wide CIC word by (D - s),
// s = min(shift, D), followed by symmetric saturation to the OUT_WIDTH signed range.
module sat_slice #(
  parameter int IN_WIDTH    = 106,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 7
) (
  input  logic signed [IN_WIDTH-1:0]    i_x,
  input  logic        [SHIFT_WIDTH-1:0] i_shift,
  output logic        [OUT_WIDTH-1:0]   o_y
);

  localparam int D = IN_WIDTH - OUT_WIDTH;

  logic        [31:0]         w_sh_ext;
  logic        [31:0]         w_s;
  logic        [31:0]         w_amt;
  logic signed [IN_WIDTH-1:0] w_y;
  logic                       w_ovf;

  assign w_sh_ext = 32'(i_shift);
  assign w_s      = (w_sh_ext > 32'(D)) ? 32'(D) : w_sh_ext;
  assign w_amt    = 32'(D) - w_s;
  assign w_y      = i_x >>> w_amt;

  // In range only when every bit from the output sign bit upward agrees.
  assign w_ovf = !((&w_y[IN_WIDTH-1:OUT_WIDTH-1]) || !(|w_y[IN_WIDTH-1:OUT_WIDTH-1]));

  always_comb begin
    o_y = w_y[OUT_WIDTH-1:0];
    if (w_ovf) begin
      o_y = w_y[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                            : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/lockin_frame_tx.sv
// Captures N_CH sliced I/Q pairs on the decimation strobe and streams them as
// SOF, seq, payload (MSB first), XOR checksum; strobes while busy are counted as drops.
module lockin_frame_tx
  import lockin_pkg::*;
#(
  parameter int         N_CH        = 2,
  parameter int         IN_WIDTH    = 106,
  parameter int         OUT_WIDTH   = 16,
  parameter int         SHIFT_WIDTH = 7,
  parameter logic [7:0] SOF         = SOF_DEFAULT
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic                       i_dstb,
  input  logic [N_CH*IN_WIDTH-1:0]   i_i,
  input  logic [N_CH*IN_WIDTH-1:0]   i_q,
  input  logic [SHIFT_WIDTH-1:0]     i_shift,
  lockin_frame_tx_if.master          tx,
  output logic                       o_busy,
  output logic [7:0]                 o_seq,
  output logic [7:0]                 o_drop_cnt
);

  localparam int NB    = nbytes(N_CH, OUT_WIDTH);
  localparam int IDX_W = $clog2(NB);
  localparam int NW    = 2 * N_CH;

  logic [OUT_WIDTH-1:0] w_sl [NW];
  logic [NB*8-1:0]      w_pay_nxt;
  logic [NB*8-1:0]      r_pay;
  logic [IDX_W-1:0]     r_idx;
  logic [7:0]           r_seq;
  logic [7:0]           r_chk;
  logic [7:0]           r_drop;
  logic [7:0]           w_byte;
  logic [7:0]           w_pay_byte;
  logic                 w_valid;
  logic                 w_xfer;
  logic                 w_cap;
  logic                 w_drop;
  logic                 w_last;
  state_t               r_state;
  state_t               w_state_nxt;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sat_slice #(
      .IN_WIDTH    (IN_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_slice_i (
      .i_x     (i_i[c*IN_WIDTH +: IN_WIDTH]),
      .i_shift (i_shift),
      .o_y     (w_sl[2*c])
    );
    sat_slice #(
      .IN_WIDTH    (IN_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_slice_q (
      .i_x     (i_q[c*IN_WIDTH +: IN_WIDTH]),
      .i_shift (i_shift),
      .o_y     (w_sl[2*c+1])
    );
  end

  // Word 0 (ch0 I) lands in the top bits so payload byte 0 is the most significant.
  always_comb begin
    w_pay_nxt = '0;
    for (int k = 0; k < NW; k++) begin
      w_pay_nxt[(NW-1-k)*OUT_WIDTH +: OUT_WIDTH] = w_sl[k];
    end
  end

  assign w_valid    = (r_state != ST_IDLE);
  assign w_xfer     = w_valid & tx.i_ready;
  assign w_cap      = i_dstb & i_en & (r_state == ST_IDLE);
  assign w_drop     = i_dstb & i_en & (r_state != ST_IDLE);
  assign w_last     = (r_idx == IDX_W'(NB-1));
  assign w_pay_byte = r_pay[(NB-1-int'(r_idx))*8 +: 8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_byte      = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_cap) w_state_nxt = ST_SOF;
      end
      ST_SOF: begin
        w_byte = SOF;
        if (w_xfer) w_state_nxt = ST_SEQ;
      end
      ST_SEQ: begin
        w_byte = r_seq;
        if (w_xfer) w_state_nxt = ST_PAY;
      end
      ST_PAY: begin
        w_byte = w_pay_byte;
        if (w_xfer && w_last) w_state_nxt = ST_CHK;
      end
      ST_CHK: begin
        w_byte = r_chk;
        if (w_xfer) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pay  <= '0;
      r_idx  <= '0;
      r_seq  <= 8'h00;
      r_chk  <= 8'h00;
      r_drop <= 8'h00;
    end else begin
      if (w_cap) begin
        r_pay <= w_pay_nxt;
        r_idx <= '0;
        r_chk <= 8'h00;
      end
      if (w_drop && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'h01;
      end
      if (w_xfer) begin
        case (r_state)
          ST_SEQ: r_chk <= r_seq;
          ST_PAY: begin
            r_chk <= r_chk ^ w_pay_byte;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
          end
          ST_CHK: r_seq <= r_seq + 8'h01;
          default: ;
        endcase
      end
    end
  end

  assign tx.o_data  = w_byte;
  assign tx.o_valid = w_valid;
  assign o_busy     = w_valid;
  assign o_seq      = r_seq;
  assign o_drop_cnt = r_drop;

endmodule

// File: tb/tb_lockin_frame_tx.sv
// Directed bench for lockin_frame_tx with N_CH=2, IN_WIDTH=32, OUT_WIDTH=16.
module tb_lockin_frame_tx;
  localparam int N_CH = 2;
  localparam int INW  = 32;
  localparam int OUTW = 16;
  localparam int SHW  = 7;
  localparam int FLEN = 11;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              dstb;
  logic [N_CH*INW-1:0] ii;
  logic [N_CH*INW-1:0] qq;
  logic [SHW-1:0]    shift;
  logic              busy;
  logic [7:0]        seq;
  logic [7:0]        drop_cnt;

  lockin_frame_tx_if tx_if ();

  lockin_frame_tx #(
    .N_CH        (N_CH),
    .IN_WIDTH    (INW),
    .OUT_WIDTH   (OUTW),
    .SHIFT_WIDTH (SHW),
    .SOF         (8'hA5)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_dstb     (dstb),
    .i_i        (ii),
    .i_q        (qq),
    .i_shift    (shift),
    .tx         (tx_if.master),
    .o_busy     (busy),
    .o_seq      (seq),
    .o_drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_seq;

  // Inputs only change at posedge+1, so a byte seen at negedge transfers on the next posedge.
  always @(negedge clk) begin
    if (rst_n && tx_if.o_valid && tx_if.i_ready) rx_q.push_back(tx_if.o_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [31:0] i0, input logic [31:0] q0,
                           input logic [31:0] i1, input logic [31:0] q1);
    ii = {i1, i0};
    qq = {q1, q0};
  endtask

  task automatic pulse();
    dstb = 1'b1;
    tick();
    dstb = 1'b0;
  endtask

  task automatic build_exp(input logic [7:0] s, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] w [4];
    logic [7:0]  x;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    x = s;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(w[k][15:8]);
      exp_q.push_back(w[k][7:0]);
      x = x ^ w[k][15:8] ^ w[k][7:0];
    end
    exp_q.push_back(x);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 600 && busy; n++) tick();
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame(input string tag);
    logic [31:0] obs;
    check({tag, "_len"}, rx_q.size(), FLEN);
    for (int k = 0; k < FLEN; k++) begin
      obs = (k < rx_q.size()) ? {24'd0, rx_q[k]} : 32'hFFFF_FFFF;
      check($sformatf("%s_b%0d", tag, k), obs, {24'd0, exp_q[k]});
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; dstb = 1'b0; shift = '0;
    tx_if.i_ready = 1'b1;
    set_words(32'd0, 32'd0, 32'd0, 32'd0);
    exp_seq = 8'h00;
    tick(); tick();
    @(negedge clk);
    check("rst_valid", {31'd0, tx_if.o_valid}, 32'd0);
    check("rst_data",  {24'd0, tx_if.o_data}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_seq",   {24'd0, seq}, 32'd0);
    check("rst_drop",  {24'd0, drop_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: basic frame
    rx_q.delete();
    set_words(32'h1234_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000);
    build_exp(exp_seq, 16'h1234, 16'hFFFF, 16'h0001, 16'h0000);
    pulse();
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    check_frame("t1");
    check("t1_chk27", (rx_q.size() == FLEN) ? {24'd0, rx_q[10]} : 32'hFFFF_FFFF, 32'h27);
    exp_seq = 8'h01;
    check("t1_seq", {24'd0, seq}, {24'd0, exp_seq});

    // 2: saturation with shift 4; i_en drops mid-frame and the frame still completes
    rx_q.delete();
    shift = 7'd4;
    set_words(32'h1234_0000, 32'hF000_0000, 32'h0000_1000, 32'hFFFF_F000);
    build_exp(exp_seq, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF);
    pulse();
    en = 1'b0;
    wait_idle();
    en = 1'b1;
    check_frame("t2");
    exp_seq = 8'h02;

    // 3: shift beyond the range clamps to 16; exact-edge and overflow values
    rx_q.delete();
    shift = 7'd100;
    set_words(32'h0000_1234, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_7FFF);
    build_exp(exp_seq, 16'h1234, 16'h8000, 16'h7FFF, 16'h8000);
    pulse();
    wait_idle();
    check_frame("t3");
    exp_seq = 8'h03;

    // 4: backpressure while the third payload byte is presented
    rx_q.delete();
    shift = 7'd0;
    set_words(32'h1234_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000);
    build_exp(exp_seq, 16'h1234, 16'hFFFF, 16'h0001, 16'h0000);
    pulse();
    for (int n = 0; n < 50 && rx_q.size() < 4; n++) tick();
    tx_if.i_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check($sformatf("t4_hold_data%0d", n), {24'd0, tx_if.o_data}, 32'hFF);
      check($sformatf("t4_hold_vld%0d", n), {31'd0, tx_if.o_valid}, 32'd1);
      tick();
    end
    tx_if.i_ready = 1'b1;
    wait_idle();
    check_frame("t4");
    exp_seq = 8'h04;

    // 5: overrun strobe in SEQ is dropped, snapshot untouched
    rx_q.delete();
    set_words(32'h0005_0000, 32'h0006_0000, 32'h0007_0000, 32'h0008_0000);
    build_exp(exp_seq, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
    pulse();
    tick();
    set_words(32'h7000_0000, 32'h7000_0000, 32'h7000_0000, 32'h7000_0000);
    pulse();
    wait_idle();
    check("t5_drop1", {24'd0, drop_cnt}, 32'd1);
    check_frame("t5a");
    exp_seq = 8'h05;
    check("t5_seq", {24'd0, seq}, {24'd0, exp_seq});

    // disabled strobe is ignored
    en = 1'b0;
    pulse();
    check("t5_en0_busy", {31'd0, busy}, 32'd0);
    check("t5_en0_drop", {24'd0, drop_cnt}, 32'd1);
    en = 1'b1;

    // next captured frame takes the following sequence number
    rx_q.delete();
    set_words(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    build_exp(exp_seq, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    pulse();
    wait_idle();
    check_frame("t5b");
    exp_seq = 8'h06;

    // drop counter saturation: stall the frame and keep strobing
    rx_q.delete();
    tx_if.i_ready = 1'b0;
    dstb = 1'b1;
    for (int n = 0; n < 300; n++) tick();
    dstb = 1'b0;
    check("t5_drop_sat", {24'd0, drop_cnt}, 32'hFF);
    tx_if.i_ready = 1'b1;
    wait_idle();
    check("t5_drop_hold", {24'd0, drop_cnt}, 32'hFF);
    exp_seq = 8'h07;
    check("t5_seq_after_sat", {24'd0, seq}, {24'd0, exp_seq});

    // 6: reset during payload
    rx_q.delete();
    pulse();
    for (int n = 0; n < 50 && rx_q.size() < 4; n++) tick();
    check("t6_in_pay", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, tx_if.o_valid}, 32'd0);
    check("t6_rst_seq",   {24'd0, seq}, 32'd0);
    check("t6_rst_drop",  {24'd0, drop_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rx_q.delete();
    exp_seq = 8'h00;
    set_words(32'h1234_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000);
    build_exp(exp_seq, 16'h1234, 16'hFFFF, 16'h0001, 16'h0000);
    pulse();
    wait_idle();
    check_frame("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
